// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the FSM state encoding
// common to the receiver and the transmitter.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line. Both flops reset
// to 1 so that a reset never looks like the leading edge of a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic rx_meta;

    // Shift the raw line through two flops every clock, idle-high on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver. The line is oversampled on an external clock-enable
// tick; the start bit is qualified at mid-bit and every following bit is
// sampled one full bit period later, i.e. also at mid-bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_CLK_ENABLE,
    input  logic                 i_RX,
    output logic [DATA_BITS-1:0] o_DATA_OUT,
    output logic                 o_DATA_VALID,
    output logic                 o_FRAME_ERROR,
    output logic                 o_BUSY
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_next;
    logic [TICK_W-1:0]    tick_cnt;
    logic [TICK_W-1:0]    tick_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [DATA_BITS-1:0] data_next;
    logic                 valid_next;
    logic                 error_next;
    logic                 rx_s;
    logic                 rx_d;

    uart_rx_sync u_sync (
        .clk  (i_CLK),
        .rst  (i_RST),
        .rx   (i_RX),
        .rx_s (rx_s)
    );

    // Remember the line value seen on the previous tick. It advances only on
    // ticks so a falling edge stays visible to the FSM until the next tick,
    // even when the tick runs slower than the system clock.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            rx_d <= 1'b1;
        end else if (i_CLK_ENABLE) begin
            rx_d <= rx_s;
        end
    end

    // Next-state, counter, shift and output-pulse logic; nothing moves off-tick
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        data_next  = o_DATA_OUT;
        valid_next = 1'b0;
        error_next = 1'b0;

        if (i_CLK_ENABLE) begin
            case (state)
                IDLE: begin
                    if (rx_d && !rx_s) begin
                        state_next = START;
                        tick_next  = '0;
                    end
                end
                START: begin
                    if (tick_cnt == HALF_LAST) begin
                        if (rx_s) begin
                            state_next = IDLE;
                        end else begin
                            state_next = DATA;
                            tick_next  = '0;
                            bit_next   = '0;
                        end
                    end else begin
                        tick_next = tick_cnt + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt == FULL_LAST) begin
                        shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_next   = bit_cnt + BIT_W'(1);
                        tick_next  = '0;
                        if (bit_cnt == BIT_LAST) begin
                            state_next = STOP;
                        end
                    end else begin
                        tick_next = tick_cnt + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt == FULL_LAST) begin
                        if (rx_s) begin
                            data_next  = shift_reg;
                            valid_next = 1'b1;
                        end else begin
                            error_next = 1'b1;
                        end
                        state_next = IDLE;
                        tick_next  = '0;
                    end else begin
                        tick_next = tick_cnt + TICK_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Register FSM, counters, shift register and the output pulses
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            o_DATA_OUT    <= '0;
            o_DATA_VALID  <= 1'b0;
            o_FRAME_ERROR <= 1'b0;
        end else begin
            state         <= state_next;
            tick_cnt      <= tick_next;
            bit_cnt       <= bit_next;
            shift_reg     <= shift_next;
            o_DATA_OUT    <= data_next;
            o_DATA_VALID  <= valid_next;
            o_FRAME_ERROR <= error_next;
        end
    end

    assign o_BUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: a table of frames plus hand-written
// sequences for false start, mid-frame reset, back-to-back and slow-tick cases.
// Every output pulse is checked against a queue of expected results.
module tb_uart_receiver;

    localparam int OS = 16;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] tx_byte;
        logic       stop_bit;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_err;
    } vec_t;

    logic       i_CLK;
    logic       i_RST;
    logic       i_CLK_ENABLE;
    logic       i_RX;
    logic [7:0] o_DATA_OUT;
    logic       o_DATA_VALID;
    logic       o_FRAME_ERROR;
    logic       o_BUSY;

    int     total = 0;
    int     bad = 0;
    int     tick_div = 1;
    longint cycle_cnt = 0;
    exp_t   exp_q[$];
    longint pulse_cycles[$];

    uart_receiver #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OS)
    ) dut (
        .i_CLK         (i_CLK),
        .i_RST         (i_RST),
        .i_CLK_ENABLE  (i_CLK_ENABLE),
        .i_RX          (i_RX),
        .o_DATA_OUT    (o_DATA_OUT),
        .o_DATA_VALID  (o_DATA_VALID),
        .o_FRAME_ERROR (o_FRAME_ERROR),
        .o_BUSY        (o_BUSY)
    );

    // 100 MHz system clock
    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    // Free-running cycle counter used to time the spacing of output pulses
    always @(posedge i_CLK) begin
        cycle_cnt <= cycle_cnt + 1;
    end

    // Oversample tick: one pulse every tick_div clocks, changed on the falling edge
    initial begin
        int div_cnt;
        div_cnt = 0;
        i_CLK_ENABLE = 1'b0;
        forever begin
            @(negedge i_CLK);
            if (div_cnt >= tick_div - 1) begin
                div_cnt = 0;
                i_CLK_ENABLE = 1'b1;
            end else begin
                div_cnt++;
                i_CLK_ENABLE = 1'b0;
            end
        end
    end

    // Scoreboard: every valid/error pulse must match the oldest expected entry
    initial begin
        exp_t e;
        forever begin
            @(negedge i_CLK);
            if (o_DATA_VALID || o_FRAME_ERROR) begin
                pulse_cycles.push_back(cycle_cnt);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_pulse: valid=%b err=%b data=%h, required no pulse",
                             o_DATA_VALID, o_FRAME_ERROR, o_DATA_OUT);
                end else begin
                    e = exp_q.pop_front();
                    if (o_DATA_VALID !== e.valid || o_FRAME_ERROR !== e.err || o_DATA_OUT !== e.data) begin
                        bad++;
                        $display("[TB] FAIL scoreboard: got valid=%b err=%b data=%h, required valid=%b err=%b data=%h",
                                 o_DATA_VALID, o_FRAME_ERROR, o_DATA_OUT, e.valid, e.err, e.data);
                    end
                end
            end
        end
    end

    // Time limit so the run always ends
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge i_CLK); while (i_CLK_ENABLE !== 1'b1);
        end
        #1;
    endtask

    task automatic push_exp(input logic [7:0] data, input logic valid, input logic err);
        exp_t e;
        e.data  = data;
        e.valid = valid;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Drive one 8N1 frame at OS ticks per bit, LSB first, then return to idle
    task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
        i_RX = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            i_RX = b[i];
            wait_ticks(OS);
        end
        i_RX = stop_bit;
        wait_ticks(OS);
        i_RX = 1'b1;
    endtask

    task automatic check_output(input string name, input longint actual, input longint required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    task automatic check_drain(input string name);
        check_output(name, exp_q.size(), 0);
    endtask

    vec_t vecs[5];

    initial begin
        int base;

        vecs[0] = '{8'h0A, 1'b1, 8'h0A, 1'b1, 1'b0};
        vecs[1] = '{8'h55, 1'b0, 8'h0A, 1'b0, 1'b1};
        vecs[2] = '{8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 8'hC3, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        // Reset state
        i_RST = 1'b1;
        i_RX  = 1'b1;
        repeat (4) @(posedge i_CLK);
        #1;
        check_output("reset_data", o_DATA_OUT, 0);
        check_output("reset_valid", o_DATA_VALID, 0);
        check_output("reset_error", o_FRAME_ERROR, 0);
        check_output("reset_busy", o_BUSY, 0);
        i_RST = 1'b0;
        wait_ticks(20);

        // Table of good and bad-stop frames, tick every clock
        for (int i = 0; i < 5; i++) begin
            push_exp(vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_err);
            apply_stimulus(vecs[i].tx_byte, vecs[i].stop_bit);
            wait_ticks(24);
            check_drain($sformatf("table_drain_%0d", i));
            check_output($sformatf("table_held_%0d", i), o_DATA_OUT, vecs[i].exp_data);
        end

        // False start: short low pulse must not produce a frame
        i_RX = 1'b0;
        wait_ticks(4);
        check_output("false_start_busy", o_BUSY, 1);
        i_RX = 1'b1;
        wait_ticks(8);
        check_output("false_start_idle", o_BUSY, 0);
        wait_ticks(16);
        check_drain("false_start_drain");
        push_exp(8'h55, 1'b1, 1'b0);
        apply_stimulus(8'h55, 1'b1);
        wait_ticks(24);
        check_drain("after_false_start_drain");

        // Reset after three data bits of 0x3C, then a clean 0xA5
        i_RX = 1'b0;
        wait_ticks(OS);
        i_RX = 1'b0; wait_ticks(OS);
        i_RX = 1'b0; wait_ticks(OS);
        i_RX = 1'b1; wait_ticks(OS);
        check_output("midframe_busy", o_BUSY, 1);
        i_RST = 1'b1;
        i_RX  = 1'b1;
        repeat (2) @(posedge i_CLK);
        #1;
        check_output("reset_mid_busy", o_BUSY, 0);
        check_output("reset_mid_data", o_DATA_OUT, 0);
        i_RST = 1'b0;
        wait_ticks(20);
        check_drain("aborted_frame_drain");
        push_exp(8'hA5, 1'b1, 1'b0);
        apply_stimulus(8'hA5, 1'b1);
        wait_ticks(24);
        check_drain("after_reset_drain");
        check_output("after_reset_data", o_DATA_OUT, 8'hA5);

        // Back-to-back frames with no idle gap
        base = pulse_cycles.size();
        push_exp(8'h80, 1'b1, 1'b0);
        push_exp(8'h01, 1'b1, 1'b0);
        apply_stimulus(8'h80, 1'b1);
        apply_stimulus(8'h01, 1'b1);
        wait_ticks(24);
        check_drain("b2b_drain");
        check_output("b2b_count", pulse_cycles.size() - base, 2);
        check_output("b2b_spacing",
                     (pulse_cycles.size() >= base + 2) ? (pulse_cycles[base + 1] - pulse_cycles[base]) : 0,
                     10 * OS);

        // Far-end transmitter stream: tick every 4th clock, one bit per 16 ticks
        tick_div = 4;
        wait_ticks(8);
        push_exp(8'h00, 1'b1, 1'b0);
        push_exp(8'hFF, 1'b1, 1'b0);
        push_exp(8'hA5, 1'b1, 1'b0);
        apply_stimulus(8'h00, 1'b1);
        wait_ticks(4);
        apply_stimulus(8'hFF, 1'b1);
        wait_ticks(4);
        apply_stimulus(8'hA5, 1'b1);
        wait_ticks(24);
        check_drain("loopback_drain");
        check_output("loopback_data", o_DATA_OUT, 8'hA5);
        check_output("loopback_busy", o_BUSY, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
